mem_if_ctrl: RTL and testbench

- Memory interface stage directly downstream of the multi-cycle control generator.
- Consumes its Mem_rd/Mem_wr requests with the datapath address and store data.
- Runs one SRAM-style bus transaction per request, with byte/half/word lane steering.
- Returns formatted load data plus the mfc (memory-function-complete) pulse that releases the control FSM stall.

---
 rtl/mem_if_ctrl_if.sv | 29 ++
 rtl/mem_if_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_if_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_ctrl_if.sv
// Request/response and SRAM bus signals of the memory interface stage.
// The slave view belongs to mem_if_ctrl; the master view drives requests and models the bus.
interface mem_if_ctrl_if;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  size;
  logic        mfc;
  logic [31:0] rdata;
  logic        err;
  logic        bus_cs;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport slave (
    input  req_rd, req_wr, addr, wdata, size, bus_rdata, bus_ready,
    output mfc, rdata, err, bus_cs, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_rd, req_wr, addr, wdata, size, bus_rdata, bus_ready,
    input  mfc, rdata, err, bus_cs, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_if_ctrl.sv
// Memory interface stage: one SRAM bus transaction per Mem_rd/Mem_wr request, lane steering, mfc pulse.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses abort with err without touching the bus.
module mem_if_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_if_ctrl_if.slave m
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        dir_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  be_q;
  logic [31:0] bwd_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req;
  logic        misalign;
  logic        timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] bwd_d;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  assign req         = m.req_rd | m.req_wr;
  assign timeout_hit = (cnt_q == TO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((m.size[1:0] == 2'b01) && m.addr[0]) ||
                    (m.size[1] && (m.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane steering of the incoming request, captured on acceptance.
  always_comb begin
    be_d  = 4'b1111;
    bwd_d = m.wdata;
    case (m.size[1:0])
      2'b00: begin
        be_d  = 4'b0001 << m.addr[1:0];
        bwd_d = {4{m.wdata[7:0]}};
      end
      2'b01: begin
        be_d  = 4'b0011 << {m.addr[1], 1'b0};
        bwd_d = {2{m.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load return: bring the addressed lane down to bit 0, then extend by funct3.
  always_comb begin
    shifted = m.bus_rdata;
    case (size_q[1:0])
      2'b00:   shifted = m.bus_rdata >> {addr_q[1:0], 3'b000};
      2'b01:   shifted = m.bus_rdata >> {addr_q[1], 4'b0000};
      default: ;
    endcase
  end

  always_comb begin
    load_fmt = shifted;
    case (size_q)
      3'b000:  load_fmt = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = misalign ? DONE : ACCESS;
      ACCESS:  if (m.bus_ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m.bus_cs    = (state_q == ACCESS);
    m.bus_we    = (state_q == ACCESS) & dir_q;
    m.mfc       = (state_q == DONE);
    m.err       = (state_q == DONE) & err_q;
    m.rdata     = rdata_q;
    m.bus_addr  = {addr_q[31:2], 2'b00};
    m.bus_be    = be_q;
    m.bus_wdata = bwd_q;
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      be_q    <= '0;
      bwd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          dir_q  <= ~m.req_rd;
          addr_q <= m.addr;
          size_q <= m.size;
          be_q   <= be_d;
          bwd_q  <= bwd_d;
          if (misalign) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (m.bus_ready) begin
            if (!dir_q) rdata_q <= load_fmt;
            err_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_if_ctrl.sv
// Bench for mem_if_ctrl: directed vector table, reset/alignment sequences, random traffic vs a byte-level model.
module tb_mem_if_ctrl;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_if_ctrl_if bus();
  mem_if_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .m(bus));

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic [31:0] rdat;
    int          wt;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and play the bus; wt = number of non-ready ACCESS cycles before bus_ready.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input logic [31:0] rdat, input int wt,
                         output int lat, output int ncs, output logic [3:0] be, output logic we,
                         output logic [31:0] baddr, output logic [31:0] bwd,
                         output logic [31:0] rdata, output logic err, output logic mfc_after);
    bit done;
    @(posedge clk); #1;
    bus.req_rd = rd; bus.req_wr = wr; bus.addr = a; bus.wdata = wd; bus.size = sz;
    @(posedge clk); #1;
    bus.req_rd = 1'b0; bus.req_wr = 1'b0; bus.addr = ~a; bus.wdata = ~wd; bus.size = ~sz;
    lat = 0; ncs = 0; be = '0; we = 1'b0; baddr = '0; bwd = '0; rdata = '0; err = 1'b0;
    mfc_after = 1'b1; done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.mfc) begin
        done  = 1'b1;
        rdata = bus.rdata;
        err   = bus.err;
      end else if (bus.bus_cs) begin
        if (ncs == 0) begin
          be = bus.bus_be; we = bus.bus_we; baddr = bus.bus_addr; bwd = bus.bus_wdata;
        end
        bus.bus_ready = (ncs == wt);
        bus.bus_rdata = (ncs == wt) ? rdat : $urandom;
        ncs++;
      end
    end
    bus.bus_ready = 1'b0;
    if (done) begin
      @(negedge clk);
      mfc_after = bus.mfc;
    end
  endtask

  // Reference: byte-granular view of the access (n bytes starting at byte offset off).
  task automatic model(input bit rd, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                       input logic [31:0] rdat, input int wt, input logic [31:0] prev,
                       output int lat, output int ncs, output logic [3:0] be,
                       output logic [31:0] bwd, output logic [31:0] rexp, output logic err);
    int n, off;
    bit mis;
    logic [31:0] v;
    n   = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    off = (n == 4) ? 0 : (n == 2) ? int'(a % 4) / 2 * 2 : int'(a % 4);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a % n) != 0;
`endif
    be = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) be[i] = 1'b1;
      bwd[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = rdat >> (8 * off);
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (!sz[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    end
    if (mis) begin
      lat = 1; ncs = 0; rexp = '0; err = 1'b1;
    end else if (wt >= TO) begin
      lat = TO + 1; ncs = TO; rexp = '0; err = 1'b1;
    end else begin
      lat = wt + 2; ncs = wt + 1; rexp = rd ? v : prev; err = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ncs, elat, encs;
    logic [3:0] be, ebe;
    logic we, err, eerr, mfc_after;
    logic [31:0] baddr, bwd, rdata, ebwd, erd, prev;
    bit rd, wr;
    logic [31:0] a, wd, rdat;
    logic [2:0] sz;
    int wt;

    tbl[0] = '{1, 0, 32'h0000_0100, 32'h1122_3344, 3'b010, 32'hDEAD_BEEF, 0,   4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 0, 2};
    tbl[1] = '{1, 0, 32'h0000_0203, 32'h0000_00C3, 3'b000, 32'h8011_2233, 3,   4'h8, 32'hC3C3_C3C3, 32'hFFFF_FF80, 0, 5};
    tbl[2] = '{1, 0, 32'h0000_0203, 32'h0000_00C3, 3'b100, 32'h8011_2233, 3,   4'h8, 32'hC3C3_C3C3, 32'h0000_0080, 0, 5};
    tbl[3] = '{0, 1, 32'h0000_0306, 32'h0000_ABCD, 3'b001, 32'h5555_5555, 0,   4'hC, 32'hABCD_ABCD, 32'h0000_0080, 0, 2};
    tbl[4] = '{1, 0, 32'h0000_0400, 32'h0000_0000, 3'b010, 32'h7777_7777, 100, 4'hF, 32'h0000_0000, 32'h0000_0000, 1, 16};
    tbl[5] = '{1, 0, 32'h0000_0044, 32'h0000_0000, 3'b010, 32'h1234_5678, 1,   4'hF, 32'h0000_0000, 32'h1234_5678, 0, 3};
    tbl[6] = '{1, 0, 32'h0000_0202, 32'h0000_0000, 3'b001, 32'h8001_7FFF, 0,   4'hC, 32'h0000_0000, 32'hFFFF_8001, 0, 2};
    tbl[7] = '{0, 1, 32'h0000_0101, 32'h1234_56A5, 3'b000, 32'h0000_0000, 0,   4'h2, 32'hA5A5_A5A5, 32'hFFFF_8001, 0, 2};
    tbl[8] = '{1, 0, 32'h0000_0000, 32'h0000_0000, 3'b101, 32'h1234_F00D, 0,   4'h3, 32'h0000_0000, 32'h0000_F00D, 0, 2};
    tbl[9] = '{0, 1, 32'h0000_07FC, 32'hCAFE_F00D, 3'b010, 32'h0000_0000, 2,   4'hF, 32'hCAFE_F00D, 32'h0000_F00D, 0, 4};

    bus.req_rd = 0; bus.req_wr = 0; bus.addr = '0; bus.wdata = '0; bus.size = '0;
    bus.bus_rdata = '0; bus.bus_ready = 0;
    rst_n = 1'b0;
    #12;
    chk("reset.mfc",       bus.mfc,       0);
    chk("reset.err",       bus.err,       0);
    chk("reset.rdata",     bus.rdata,     0);
    chk("reset.bus_cs",    bus.bus_cs,    0);
    chk("reset.bus_we",    bus.bus_we,    0);
    chk("reset.bus_addr",  bus.bus_addr,  0);
    chk("reset.bus_be",    {28'h0, bus.bus_be}, 0);
    chk("reset.bus_wdata", bus.bus_wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].rdat, tbl[i].wt,
              lat, ncs, be, we, baddr, bwd, rdata, err, mfc_after);
      chk($sformatf("tbl[%0d].lat", i),       lat,   tbl[i].lat);
      chk($sformatf("tbl[%0d].cs_cycles", i), ncs,   tbl[i].lat - 1);
      chk($sformatf("tbl[%0d].be", i),        {28'h0, be}, {28'h0, tbl[i].be});
      chk($sformatf("tbl[%0d].we", i),        we,    !tbl[i].rd);
      chk($sformatf("tbl[%0d].bus_addr", i),  baddr, tbl[i].a & 32'hFFFF_FFFC);
      chk($sformatf("tbl[%0d].bus_wdata", i), bwd,   tbl[i].bwd);
      chk($sformatf("tbl[%0d].rdata", i),     rdata, tbl[i].rdata);
      chk($sformatf("tbl[%0d].err", i),       err,   tbl[i].err);
      chk($sformatf("tbl[%0d].mfc_pulse", i), mfc_after, 0);
    end
    prev = 32'h0000_F00D;

    // Reset in the middle of a stalled access.
    @(posedge clk); #1;
    bus.req_rd = 1'b1; bus.addr = 32'h0000_0500; bus.size = 3'b010;
    @(posedge clk); #1;
    bus.req_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.cs_before", bus.bus_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.cs_dropped", bus.bus_cs, 0);
    chk("rst_mid.no_mfc",     bus.mfc,    0);
    @(negedge clk);
    chk("rst_mid.still_idle", bus.bus_cs, 0);
    rst_n = 1'b1;
    run_txn(1, 0, 32'h0000_0600, 32'h0, 3'b010, 32'h0BAD_CAFE, 0,
            lat, ncs, be, we, baddr, bwd, rdata, err, mfc_after);
    chk("rst_mid.after.lat",   lat,   2);
    chk("rst_mid.after.rdata", rdata, 32'h0BAD_CAFE);
    chk("rst_mid.after.err",   err,   0);
    prev = 32'h0BAD_CAFE;

    // Word load at a non-word-aligned address.
    run_txn(1, 0, 32'h0000_0102, 32'h0, 3'b010, 32'h1357_9BDF, 0,
            lat, ncs, be, we, baddr, bwd, rdata, err, mfc_after);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign.lat",       lat,   1);
    chk("misalign.cs_cycles", ncs,   0);
    chk("misalign.err",       err,   1);
    chk("misalign.rdata",     rdata, 0);
    prev = 32'h0;
`else
    chk("misalign.lat",      lat,   2);
    chk("misalign.bus_addr", baddr, 32'h0000_0100);
    chk("misalign.be",       {28'h0, be}, 32'hF);
    chk("misalign.rdata",    rdata, 32'h1357_9BDF);
    chk("misalign.err",      err,   0);
    prev = 32'h1357_9BDF;
`endif

    for (int i = 0; i < 150; i++) begin
      rd   = $urandom_range(0, 1);
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a    = $urandom;
      wd   = $urandom;
      sz   = 3'($urandom_range(0, 7));
      rdat = $urandom;
      wt   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      model(rd, a, wd, sz, rdat, wt, prev, elat, encs, ebe, ebwd, erd, eerr);
      run_txn(rd, wr, a, wd, sz, rdat, wt, lat, ncs, be, we, baddr, bwd, rdata, err, mfc_after);
      chk($sformatf("rnd[%0d].lat", i),       lat,   elat);
      chk($sformatf("rnd[%0d].cs_cycles", i), ncs,   encs);
      chk($sformatf("rnd[%0d].rdata", i),     rdata, erd);
      chk($sformatf("rnd[%0d].err", i),       err,   eerr);
      chk($sformatf("rnd[%0d].mfc_pulse", i), mfc_after, 0);
      if (encs > 0) begin
        chk($sformatf("rnd[%0d].be", i),        {28'h0, be}, {28'h0, ebe});
        chk($sformatf("rnd[%0d].we", i),        we,    !rd);
        chk($sformatf("rnd[%0d].bus_addr", i),  baddr, a & 32'hFFFF_FFFC);
        chk($sformatf("rnd[%0d].bus_wdata", i), bwd,   ebwd);
      end
      prev = erd;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
